vec_exec_ctrl: RTL and testbench
================================

VEC_EXEC_CTRL -- requirements
Module: vec_exec_ctrl

Interface
REQ-001 The block SHALL have parameter LANES, default 8, setting the vector lanes per instruction (power of 2, 2..16).
REQ-002 The block SHALL have parameter DIV_CYCLES, default 4, setting the cycles per lane for DIV (>=2).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  the asynchronous, active-low reset.
REQ-006 issue_valid  in  1  an instruction is offered this cycle.
REQ-007 issue_opcode  in  4  the opcode of the offered instruction.
REQ-008 kill  in  1  synchronous flush of the instruction in flight.
REQ-009 issue_ready  out  1  the block can accept an instruction.
REQ-010 alu_op  out  3  the ALU operation select for the vector ALU.
REQ-011 lane_idx  out  clog2(LANES)  the lane currently driven to the ALU.
REQ-012 lane_we  out  1  write the ALU result of lane_idx to the vector register file.
REQ-013 flag_we  out  1  write the compare flags of lane_idx.
REQ-014 stall  out  1  the front-end pipeline holds.
REQ-015 done  out  1  one-cycle pulse when an instruction retires.

Function
REQ-016 Opcode decode SHALL be: 0100, 1101, 1110, 1111, 0000, 0001 -> 001 PASS; 1000 -> 010 ADD; 1001 -> 011 SUB; 0101, 0110 -> 011 SUB-compare; 1010 -> 100 MUL; 1011 -> 101 DIV; all others -> 000 NOP.
REQ-017 The FSM SHALL have states IDLE, EXEC, DONE.
REQ-018 IDLE: issue_ready=1, stall=0, alu_op=000, lane_we=0, flag_we=0.
REQ-019 An issue SHALL be accepted only on the cycle where issue_valid and issue_ready are both 1; the opcode is latched then.
REQ-020 An accepted NOP SHALL go IDLE->DONE directly, with no lane cycles.
REQ-021 An accepted non-NOP SHALL go IDLE->EXEC with lane_idx=0.
REQ-022 EXEC SHALL drive the latched alu_op every cycle.
REQ-023 For PASS, ADD, SUB and MUL, each lane SHALL take 1 cycle with lane_we=1; lane_idx increments each cycle.
REQ-024 For DIV, each lane SHALL take DIV_CYCLES cycles; lane_we=1 only on the last of them, and lane_idx advances after it.
REQ-025 For compares (0101, 0110), each lane SHALL take 1 cycle with flag_we=1 and lane_we=0.
REQ-026 After the final cycle of lane LANES-1, the FSM SHALL go to DONE; lane_idx SHALL not wrap within an instruction.
REQ-027 DONE SHALL last 1 cycle: done=1, issue_ready=0, lane_we=0, flag_we=0; the FSM then returns to IDLE.
REQ-028 stall SHALL be 1 in EXEC and DONE and 0 in IDLE.
REQ-029 issue_ready SHALL be 1 only in IDLE; issue_valid outside IDLE SHALL be ignored and not queued.
REQ-030 Latency for a 1-cycle op accepted at cycle N: lane writes at N+1..N+LANES, done at N+LANES+1, next accept at N+LANES+2 at the earliest.
REQ-031 Latency for DIV accepted at cycle N: done at N+LANES*DIV_CYCLES+1.
REQ-032 kill=1 in EXEC or DONE SHALL return the FSM to IDLE on the next edge; lane_we, flag_we and done are forced to 0 in the kill cycle; lane_idx and the DIV counter clear.
REQ-033 kill=1 in IDLE SHALL take priority over issue_valid: no acceptance occurs.

Reset
REQ-034 While rst_n=0, the FSM SHALL be in IDLE, lane_idx=0, the DIV counter=0, the latched opcode=0000, alu_op=000, lane_we=0, flag_we=0, done=0, stall=0, issue_ready=1.
REQ-035 Reset asserted mid-instruction SHALL abandon it immediately, with no further lane_we or done.

Verification
REQ-036 ADD (1000) accepted at cycle 0, LANES=8 -> alu_op=010; lane_we=1 at cycles 1..8 with lane_idx 0..7; done at cycle 9; issue_ready=1 at cycle 10.
REQ-037 DIV (1011) accepted at cycle 0, DIV_CYCLES=4 -> lane_we at cycles 4, 8, ..., 32; done at cycle 33; stall=1 for cycles 1..33.
REQ-038 CMPI (0110) -> alu_op=011; flag_we=1 and lane_we=0 for 8 cycles; then done.
REQ-039 Opcode 0111 -> alu_op=000; no lane_we; done 1 cycle after acceptance.
REQ-040 kill at lane 3 of MUL -> IDLE next cycle; no done; lane_idx=0; a new issue is accepted on the following cycle.
REQ-041 rst_n dropped at cycle 5 of ADD, issue_valid held high throughout -> all outputs at reset values immediately; no lane_we or done while rst_n=0; an issue is accepted on the first edge after release.

Source files
------------

// File: rtl/vec_exec_ctrl.sv
// vec_exec_ctrl -- sequences one vector instruction across LANES lanes.
//
// An instruction is accepted in IDLE, decoded to an ALU select, then walked
// lane by lane in EXEC (DIV lanes take DIV_CYCLES cycles each), and retired
// with a one-cycle DONE. kill flushes the instruction in flight.
//
// Ports:
//   clk, rst_n    single clock, asynchronous active-low reset
//   issue_valid   instruction offered this cycle
//   issue_opcode  4-bit opcode of the offered instruction
//   kill          synchronous flush of the instruction in flight
//   issue_ready   block can accept an instruction (IDLE only)
//   alu_op        ALU operation select (000 outside EXEC)
//   lane_idx      lane currently driven to the ALU
//   lane_we       write ALU result of lane_idx to the register file
//   flag_we       write compare flags of lane_idx
//   stall         front end holds (EXEC and DONE)
//   done          one-cycle retire pulse
module vec_exec_ctrl #(
    parameter int LANES      = 8,
    parameter int DIV_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    input  logic [3:0]               issue_opcode,
    input  logic                     kill,
    output logic                     issue_ready,
    output logic [2:0]               alu_op,
    output logic [$clog2(LANES)-1:0] lane_idx,
    output logic                     lane_we,
    output logic                     flag_we,
    output logic                     stall,
    output logic                     done
);
    localparam int LW = $clog2(LANES);
    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
    typedef enum logic [1:0] {K_NOP, K_ONE, K_DIV, K_CMP} kind_t;

    typedef struct packed {
        logic [2:0] alu;
        kind_t      kind;
    } dec_t;

    function automatic dec_t decode(input logic [3:0] opc);
        dec_t d;
        d = '{alu: 3'b000, kind: K_NOP};
        unique case (opc)
            4'b0100, 4'b1101, 4'b1110,
            4'b1111, 4'b0000, 4'b0001: d = '{alu: 3'b001, kind: K_ONE};
            4'b1000:                   d = '{alu: 3'b010, kind: K_ONE};
            4'b1001:                   d = '{alu: 3'b011, kind: K_ONE};
            4'b0101, 4'b0110:          d = '{alu: 3'b011, kind: K_CMP};
            4'b1010:                   d = '{alu: 3'b100, kind: K_ONE};
            4'b1011:                   d = '{alu: 3'b101, kind: K_DIV};
            default:                   d = '{alu: 3'b000, kind: K_NOP};
        endcase
        return d;
    endfunction

    state_t        state;
    logic [3:0]    op_q;
    logic [CW-1:0] div_cnt;
    logic          lane_we_q, flag_we_q, done_q;
    dec_t          dec_in, dec_q;
    logic          last_sub;

    assign dec_in   = decode(issue_opcode);
    assign dec_q    = decode(op_q);
    // Final cycle of the current lane: every cycle for single-cycle ops,
    // the last DIV_CYCLES slot for DIV.
    assign last_sub = (dec_q.kind != K_DIV) || (div_cnt == DIV_LAST);

    // Write strobes and done are squashed combinationally in a kill cycle.
    assign lane_we = lane_we_q & ~kill;
    assign flag_we = flag_we_q & ~kill;
    assign done    = done_q    & ~kill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= '0;
            div_cnt     <= '0;
            lane_idx    <= '0;
            alu_op      <= 3'b000;
            lane_we_q   <= 1'b0;
            flag_we_q   <= 1'b0;
            done_q      <= 1'b0;
            stall       <= 1'b0;
            issue_ready <= 1'b1;
        end else if (state == S_DONE || (kill && state != S_IDLE)) begin
            // Retire or flush: both land back in IDLE with clean counters.
            state       <= S_IDLE;
            div_cnt     <= '0;
            lane_idx    <= '0;
            alu_op      <= 3'b000;
            lane_we_q   <= 1'b0;
            flag_we_q   <= 1'b0;
            done_q      <= 1'b0;
            stall       <= 1'b0;
            issue_ready <= 1'b1;
        end else if (state == S_IDLE) begin
            if (issue_valid && !kill) begin
                op_q        <= issue_opcode;
                div_cnt     <= '0;
                lane_idx    <= '0;
                stall       <= 1'b1;
                issue_ready <= 1'b0;
                if (dec_in.kind == K_NOP) begin
                    state  <= S_DONE;
                    done_q <= 1'b1;
                end else begin
                    state     <= S_EXEC;
                    alu_op    <= dec_in.alu;
                    lane_we_q <= (dec_in.kind == K_ONE);
                    flag_we_q <= (dec_in.kind == K_CMP);
                end
            end
        end else begin
            // S_EXEC
            if (last_sub) begin
                div_cnt <= '0;
                if (lane_idx == LANE_LAST) begin
                    // lane_idx holds at the last lane through DONE; no wrap.
                    state     <= S_DONE;
                    done_q    <= 1'b1;
                    lane_we_q <= 1'b0;
                    flag_we_q <= 1'b0;
                    alu_op    <= 3'b000;
                end else begin
                    lane_idx <= lane_idx + 1'b1;
                    if (dec_q.kind == K_DIV) lane_we_q <= 1'b0;
                end
            end else begin
                div_cnt   <= div_cnt + 1'b1;
                lane_we_q <= ((div_cnt + 1'b1) == DIV_LAST);
            end
        end
    end
endmodule

// File: tb/tb_vec_exec_ctrl.sv
// Bench for vec_exec_ctrl: every cycle is compared against a queue-based
// model that expands each accepted instruction into its expected per-cycle
// outputs; an opcode table checks per-instruction totals and latency, and
// hand-written sequences cover kill and mid-instruction reset.
module tb_vec_exec_ctrl;
    localparam int LANES      = 8;
    localparam int DIV_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue_valid = 1'b0;
    logic [3:0] issue_opcode = 4'h0;
    logic       kill = 1'b0;
    logic       issue_ready, lane_we, flag_we, stall, done;
    logic [2:0] alu_op;
    logic [$clog2(LANES)-1:0] lane_idx;

    int checks = 0;
    int errors = 0;

    vec_exec_ctrl #(.LANES(LANES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
        .issue_opcode(issue_opcode), .kill(kill), .issue_ready(issue_ready),
        .alu_op(alu_op), .lane_idx(lane_idx), .lane_we(lane_we),
        .flag_we(flag_we), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit ready, stall, lw, fw, dn;
        bit exec, idle;
        int alu, idx;
    } exp_t;

    exp_t mq[$];

    function automatic exp_t idle_rec();
        exp_t e;
        e = '{ready: 1, stall: 0, lw: 0, fw: 0, dn: 0, exec: 0, idle: 1, alu: 0, idx: 0};
        return e;
    endfunction

    // kind: 0 nop, 1 single-cycle write, 2 div, 3 compare
    function automatic int op_kind(input logic [3:0] o, output int alu);
        case (o)
            4'b0100, 4'b1101, 4'b1110, 4'b1111, 4'b0000, 4'b0001: begin alu = 1; return 1; end
            4'b1000: begin alu = 2; return 1; end
            4'b1001: begin alu = 3; return 1; end
            4'b0101, 4'b0110: begin alu = 3; return 3; end
            4'b1010: begin alu = 4; return 1; end
            4'b1011: begin alu = 5; return 2; end
            default: begin alu = 0; return 0; end
        endcase
    endfunction

    function automatic void push_instr(input logic [3:0] o);
        int alu, kind, per;
        exp_t e;
        kind = op_kind(o, alu);
        per  = (kind == 2) ? DIV_CYCLES : 1;
        if (kind != 0)
            for (int l = 0; l < LANES; l++)
                for (int c = 0; c < per; c++) begin
                    e = '{ready: 0, stall: 1, lw: (kind != 3) && (c == per - 1),
                          fw: (kind == 3), dn: 0, exec: 1, idle: 0, alu: alu, idx: l};
                    mq.push_back(e);
                end
        e = '{ready: 0, stall: 1, lw: 0, fw: 0, dn: 1, exec: 0, idle: 0, alu: 0, idx: 0};
        mq.push_back(e);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    int obs_ready, obs_lw, obs_fw, obs_dn, obs_stall, obs_alu, obs_idx;

    // One clock cycle: drive at negedge, compare against model, advance model.
    task automatic step(input bit v, input logic [3:0] o, input bit k);
        exp_t e;
        @(negedge clk);
        issue_valid = v; issue_opcode = o; kill = k;
        #1;
        if (!rst_n || mq.size() == 0) e = idle_rec();
        else e = mq[0];
        if (k && !e.idle) begin e.lw = 0; e.fw = 0; e.dn = 0; end
        obs_ready = issue_ready; obs_lw = lane_we; obs_fw = flag_we;
        obs_dn = done; obs_stall = stall; obs_alu = alu_op; obs_idx = lane_idx;
        chk("issue_ready", obs_ready, e.ready);
        chk("stall", obs_stall, e.stall);
        chk("lane_we", obs_lw, e.lw);
        chk("flag_we", obs_fw, e.fw);
        chk("done", obs_dn, e.dn);
        if (e.exec || e.idle) begin
            chk("alu_op", obs_alu, e.alu);
            chk("lane_idx", obs_idx, e.idx);
        end
        @(posedge clk);
        if (!rst_n) mq.delete();
        else if (mq.size() != 0) begin
            if (k) mq.delete();
            else void'(mq.pop_front());
        end else if (v && !k) push_instr(o);
    endtask

    typedef struct {
        logic [3:0] opc;
        int alu, nlw, nfw, lat;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int lw, fw, lat, alu;
        tbl = '{
            '{4'b0000, 1, 8, 0, 9},  '{4'b0001, 1, 8, 0, 9},
            '{4'b0010, 0, 0, 0, 1},  '{4'b0011, 0, 0, 0, 1},
            '{4'b0100, 1, 8, 0, 9},  '{4'b0101, 3, 0, 8, 9},
            '{4'b0110, 3, 0, 8, 9},  '{4'b0111, 0, 0, 0, 1},
            '{4'b1000, 2, 8, 0, 9},  '{4'b1001, 3, 8, 0, 9},
            '{4'b1010, 4, 8, 0, 9},  '{4'b1011, 5, 8, 0, 33},
            '{4'b1100, 0, 0, 0, 1},  '{4'b1101, 1, 8, 0, 9},
            '{4'b1110, 1, 8, 0, 9},  '{4'b1111, 1, 8, 0, 9}
        };

        // Reset values, valid held high while in reset.
        step(1, 4'b1000, 0);
        step(1, 4'b1000, 0);
        #2 rst_n = 1'b1;

        // Opcode table: totals per instruction and retire latency.
        foreach (tbl[i]) begin
            step(1, tbl[i].opc, 0);
            lw = 0; fw = 0; lat = 0; alu = -1;
            for (int c = 1; c <= 100; c++) begin
                step(0, 4'h0, 0);
                if (c == 1) alu = obs_alu;
                lw += obs_lw; fw += obs_fw;
                if (obs_dn != 0) begin lat = c; break; end
            end
            chk($sformatf("tbl%0d_alu", i), alu, tbl[i].alu);
            chk($sformatf("tbl%0d_lane_writes", i), lw, tbl[i].nlw);
            chk($sformatf("tbl%0d_flag_writes", i), fw, tbl[i].nfw);
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
            step(0, 4'h0, 0);
            chk($sformatf("tbl%0d_ready_after", i), obs_ready, 1);
        end

        // Kill at lane 3 of MUL, then immediate re-issue.
        step(1, 4'b1010, 0);
        for (int c = 0; c < 3; c++) step(0, 4'h0, 0);
        step(0, 4'h0, 1);
        chk("kill_lane3_lw", obs_lw, 0);
        step(1, 4'b1000, 0);
        chk("kill_ready_next", obs_ready, 1);
        chk("kill_idx_clear", obs_idx, 0);
        step(0, 4'h0, 0);
        chk("kill_reissue_accepted", obs_stall, 1);
        for (int c = 0; c < 10; c++) step(0, 4'h0, 0);

        // Kill in IDLE beats issue_valid.
        step(1, 4'b1000, 1);
        step(0, 4'h0, 0);
        chk("kill_idle_no_accept", obs_stall, 0);

        // Kill in DONE suppresses done.
        step(1, 4'b0111, 0);
        step(0, 4'h0, 1);
        chk("kill_done_pulse", obs_dn, 0);
        step(0, 4'h0, 0);
        chk("kill_done_idle", obs_ready, 1);

        // Reset dropped mid-ADD with valid held high.
        step(1, 4'b1000, 0);
        for (int c = 0; c < 4; c++) step(1, 4'b1000, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", issue_ready, 1);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_lw", lane_we, 0);
        chk("rst_mid_idx", lane_idx, 0);
        chk("rst_mid_alu", alu_op, 0);
        for (int c = 0; c < 3; c++) step(1, 4'b1000, 0);
        #2 rst_n = 1'b1;
        step(1, 4'b1000, 0);
        step(0, 4'h0, 0);
        chk("rst_release_accept", obs_stall, 1);
        for (int c = 0; c < 10; c++) step(0, 4'h0, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++)
            step(bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 49) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
